// File: rtl/inst_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch
// Purpose  : Instruction prefetch queue. Owns the sequential fetch PC, keeps
//            up to DEPTH requests outstanding to a variable-latency
//            instruction memory and buffers returned instructions (with their
//            PCs) in an in-order FIFO whose head is presented to fetch.
//            A redirect flushes the queue and discards stale responses.
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch #(
  parameter int               WIDTH    = 32,
  parameter int               INST_LEN = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [WIDTH-1:0]    redirect_pc,
  input  logic                deq_ready,
  output logic                inst_valid,
  output logic [INST_LEN-1:0] inst_o,
  output logic [WIDTH-1:0]    pc_o,
  output logic                imem_req_valid,
  output logic [WIDTH-1:0]    imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data
);

  localparam int                  PW    = $clog2(DEPTH);
  localparam int                  CW    = PW + 1;
  localparam logic [INST_LEN-1:0] C_NOP = INST_LEN'(32'h0000_0013);

  logic [WIDTH-1:0]    r_fetch_pc;
  logic [WIDTH-1:0]    r_resp_pc;
  logic [WIDTH-1:0]    r_pc_mem   [DEPTH];
  logic [INST_LEN-1:0] r_inst_mem [DEPTH];
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_inflight;
  logic [CW-1:0]       r_drop_cnt;

  logic                w_credit;
  logic                w_req_fire;
  logic                w_resp_drop;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_inflight_nxt;

  // Buffered entries plus outstanding requests may never exceed DEPTH, so a
  // response always has a free slot and no push-while-full can happen.
  assign w_credit       = ({1'b0, r_count} + {1'b0, r_inflight}) < (CW + 1)'(DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses belonging to a flushed stream are swallowed while drop_cnt > 0.
  assign w_resp_drop    = imem_resp_valid && (r_drop_cnt != '0);
  assign w_push         = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;

  assign inst_valid     = !reset && (r_count != '0);
  assign w_pop          = inst_valid && deq_ready && !redirect_valid;
  assign inst_o         = inst_valid ? r_inst_mem[r_rd_ptr] : C_NOP;
  assign pc_o           = inst_valid ? r_pc_mem[r_rd_ptr] : '0;

  // No request issues on a redirect, so after one every outstanding response
  // is stale: drop_cnt simply becomes the post-update in-flight count.
  assign w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(imem_resp_valid);

  // FIFO payload storage; contents need no reset because count gates them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_resp_pc;
      r_inst_mem[r_wr_ptr] <= imem_resp_data;
    end
  end

  // Control state: reset, then redirect flush, then normal request/response/dequeue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_resp_pc  <= redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_inflight_nxt;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + WIDTH'(4);
      end
      if (w_resp_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + WIDTH'(4);
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch
// Purpose  : Directed self-checking bench for inst_prefetch with a small
//            in-order variable-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;
  int n_acc    = 0;
  int a0;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] exp_pc   = 32'h0;
  logic [31:0] exp_req  = 32'h0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  inst_prefetch #(
    .WIDTH    (32),
    .INST_LEN (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .deq_ready       (deq_ready),
    .inst_valid      (inst_valid),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is a fixed scramble of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive the memory response for the current cycle and let logic settle.
  task automatic pre();
    if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
  endtask

  // Stream monitors, then the clock edge and memory-model update.
  task automatic post();
    logic        fr;
    logic        fs;
    logic        rs;
    logic [31:0] a;
    if (reset) begin
      exp_pc    = 32'h0;
      exp_req   = 32'h0;
      prev_pend = 1'b0;
    end else if (redirect_valid) begin
      exp_pc    = redirect_pc;
      exp_req   = redirect_pc;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (inst_valid && deq_ready) begin
        chk("pop_pc", pc_o, exp_pc);
        chk("pop_inst", inst_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr_seq", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
        n_acc++;
      end
      prev_pend = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
    end
    fr = imem_req_valid && imem_req_ready;
    fs = imem_resp_valid;
    rs = reset;
    a  = imem_req_addr;
    @(posedge clk);
    #1;
    if (rs) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (fs) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (fr) begin
        mq_addr.push_back(a);
        mq_due.push_back(cyc + lat);
        chk("outstanding_le_depth", {31'b0, (mq_addr.size() <= DEPTH)}, 32'd1);
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      pre();
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_pc_o", pc_o, 32'h0);
      chk("rst_inst_o", inst_o, NOP);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      post();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    deq_ready      = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    #1;

    // ---- single-cycle memory, streaming -----------------------------------
    lat = 1;
    do_reset(2);
    pre();
    chk("s1_c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("s1_c0_req_addr", imem_req_addr, 32'h0);
    chk("s1_c0_inst_valid", {31'b0, inst_valid}, 32'd0);
    post();
    pre();
    chk("s1_c1_req_addr", imem_req_addr, 32'h4);
    chk("s1_c1_inst_valid", {31'b0, inst_valid}, 32'd0);
    post();
    pre();
    chk("s1_c2_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("s1_c2_pc_o", pc_o, 32'h0);
    chk("s1_c2_inst_o", inst_o, mem_word(32'h0));
    chk("s1_c2_req_addr", imem_req_addr, 32'h8);
    post();
    repeat (6) cycle();
    pre();
    chk("s1_steady_pc_o", pc_o, 32'h1C);
    post();

    // ---- fetch stall fills the queue --------------------------------------
    lat = 1;
    deq_ready = 1'b0;
    do_reset(1);
    a0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      pre();
      chk("s2_fill_req_valid", {31'b0, imem_req_valid}, 32'd1);
      post();
    end
    for (int i = 0; i < 6; i++) begin
      pre();
      chk("s2_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("s2_full_inst_valid", {31'b0, inst_valid}, 32'd1);
      post();
    end
    chk("s2_accepted", n_acc - a0, 32'd4);
    deq_ready = 1'b1;
    pre();
    chk("s2_drain_pc0", pc_o, 32'h0);
    chk("s2_drain_req_valid", {31'b0, imem_req_valid}, 32'd0);
    post();
    pre();
    chk("s2_drain_pc4", pc_o, 32'h4);
    chk("s2_resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("s2_resume_req_addr", imem_req_addr, 32'h10);
    post();
    pre();
    chk("s2_drain_pc8", pc_o, 32'h8);
    post();
    pre();
    chk("s2_drain_pc12", pc_o, 32'hC);
    post();
    pre();
    chk("s2_next_pc16", pc_o, 32'h10);
    post();

    // ---- redirect with three requests in flight ---------------------------
    lat = 4;
    deq_ready = 1'b1;
    do_reset(1);
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    pre();
    chk("s3_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    post();
    redirect_valid = 1'b0;
    pre();
    chk("s3_new_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("s3_new_req_addr", imem_req_addr, 32'h100);
    chk("s3_c4_inst_valid", {31'b0, inst_valid}, 32'd0);
    post();
    for (int i = 0; i < 4; i++) begin
      pre();
      chk("s3_dropped_inst_valid", {31'b0, inst_valid}, 32'd0);
      post();
    end
    pre();
    chk("s3_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("s3_first_pc", pc_o, 32'h100);
    chk("s3_first_inst", inst_o, mem_word(32'h100));
    post();

    // ---- redirect coincident with a response and a dequeue ----------------
    lat = 2;
    deq_ready = 1'b1;
    do_reset(1);
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    pre();
    chk("s4_redir_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("s4_redir_pc_o", pc_o, 32'h0);
    chk("s4_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    post();
    redirect_valid = 1'b0;
    pre();
    chk("s4_flush_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("s4_flush_pc_o", pc_o, 32'h0);
    chk("s4_new_req_addr", imem_req_addr, 32'h200);
    post();
    for (int i = 0; i < 2; i++) begin
      pre();
      chk("s4_stale_inst_valid", {31'b0, inst_valid}, 32'd0);
      post();
    end
    pre();
    chk("s4_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("s4_first_pc", pc_o, 32'h200);
    chk("s4_first_inst", inst_o, mem_word(32'h200));
    post();

    // ---- memory ready toggling --------------------------------------------
    lat = 1;
    deq_ready = 1'b1;
    do_reset(1);
    a0 = n_acc;
    for (int i = 0; i < 14; i++) begin
      imem_req_ready = (i % 2 == 0);
      cycle();
    end
    imem_req_ready = 1'b1;
    chk("s5_accepted", n_acc - a0, 32'd7);

    // ---- reset with two buffered and two in flight ------------------------
    lat = 2;
    deq_ready = 1'b0;
    do_reset(1);
    repeat (3) cycle();
    pre();
    chk("s6_pre_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("s6_pre_pc_o", pc_o, 32'h0);
    post();
    reset = 1'b1;
    pre();
    chk("s6_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("s6_rst_inst_o", inst_o, NOP);
    chk("s6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    post();
    reset = 1'b0;
    deq_ready = 1'b1;
    pre();
    chk("s6_after_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("s6_after_pc_o", pc_o, 32'h0);
    chk("s6_after_inst_o", inst_o, NOP);
    chk("s6_after_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("s6_after_req_addr", imem_req_addr, 32'h0);
    post();
    repeat (2) cycle();
    pre();
    chk("s6_restart_pc", pc_o, 32'h0);
    chk("s6_restart_inst", inst_o, mem_word(32'h0));
    post();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
